mux4_rr_arbiter: RTL and testbench

Sequential round-robin arbiter that shares one 4:1 select datapath among four requesters. It drives the select lines (s1, s0) and emits a registered, valid-qualified copy of the granted input. A per-grant hold limit (MAX_HOLD) bounds how long one requester can keep the mux while others are waiting. It sits directly in front of the existing 4:1 mux and is its only source of select lines.

---
 rtl/mux4_arb_pkg.sv | 40 ++++
 rtl/rr_pick4.sv | 21 ++
 rtl/mux4_rr_arbiter.sv | 112 +++++++++++
 tb/tb_mux4_rr_arbiter.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/mux4_arb_pkg.sv
// Shared types and the round-robin search helper for the 4-way select arbiter.
package mux4_arb_pkg;

  localparam int IDX_W = 2;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  typedef struct packed {
    logic             found;
    logic [IDX_W-1:0] idx;
  } pick_t;

  // First requester at or after ptr+1 (mod 4), ignoring masked requesters.
  // Walks the order backwards so the last write is the highest priority.
  function automatic pick_t rr_next(input logic [3:0]       req,
                                    input logic [IDX_W-1:0] ptr,
                                    input logic [3:0]       mask);
    pick_t            r;
    logic [3:0]       elig;
    logic [IDX_W-1:0] n;
    r    = '0;
    elig = req & ~mask;
    for (int k = 4; k >= 1; k--) begin
      n = ptr + IDX_W'(k);
      if (elig[n]) begin
        r.found = 1'b1;
        r.idx   = n;
      end
    end
    return r;
  endfunction

  function automatic logic [3:0] idx_onehot(input logic [IDX_W-1:0] idx);
    return 4'b0001 << idx;
  endfunction

endpackage

// File: rtl/rr_pick4.sv
// Combinational round-robin picker: next eligible requester after ptr.
module rr_pick4
  import mux4_arb_pkg::*;
(
  input  logic [3:0]       req,
  input  logic [IDX_W-1:0] ptr,
  input  logic [3:0]       excl,
  output logic [IDX_W-1:0] idx,
  output logic             found
);

  pick_t pick;

  // Search is pure function of the inputs; no state lives here.
  always_comb begin
    pick  = rr_next(req, ptr, excl);
    idx   = pick.idx;
    found = pick.found;
  end

endmodule

// File: rtl/mux4_rr_arbiter.sv
// Round-robin arbiter driving the select lines of a shared 4:1 mux, with a
// per-grant hold limit and a registered, valid-qualified data output.
//
// state | meaning
// IDLE  | no grant; select lines keep the last granted index
// GRANT | requester ptr owns the mux; cnt counts extra cycles held
module mux4_rr_arbiter
  import mux4_arb_pkg::*;
#(
  parameter int W        = 1,
  parameter int MAX_HOLD = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [3:0]   req,
  input  logic [W-1:0] i0,
  input  logic [W-1:0] i1,
  input  logic [W-1:0] i2,
  input  logic [W-1:0] i3,
  output logic [3:0]   gnt,
  output logic         s1,
  output logic         s0,
  output logic [W-1:0] out,
  output logic         out_valid
);

  localparam int              CNT_W    = $clog2(MAX_HOLD) + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_HOLD - 1);

  state_t           state;
  logic [IDX_W-1:0] ptr;
  logic [CNT_W-1:0] cnt;
  logic [3:0]       excl;
  logic [IDX_W-1:0] pick_idx;
  logic             pick_found;
  logic             take;
  logic [W-1:0]     sel_data;

  // While granted, the holder is excluded so "found" means someone else waits.
  always_comb begin
    excl = (state == GRANT) ? idx_onehot(ptr) : 4'b0000;
  end

  rr_pick4 u_pick (
    .req   (req),
    .ptr   (ptr),
    .excl  (excl),
    .idx   (pick_idx),
    .found (pick_found)
  );

  // A new grant is taken when idle, when the holder lets go, or when the
  // holder has used its full allowance and someone else is waiting.
  always_comb begin
    take = 1'b0;
    if (pick_found) begin
      if (state == IDLE)        take = 1'b1;
      else if (!req[ptr])       take = 1'b1;
      else if (cnt == CNT_LAST) take = 1'b1;
    end
  end

  // 4:1 data select driven by the registered select lines.
  always_comb begin
    case ({s1, s0})
      2'd0:    sel_data = i0;
      2'd1:    sel_data = i1;
      2'd2:    sel_data = i2;
      default: sel_data = i3;
    endcase
  end

  // Arbitration FSM plus registered grant, select and data outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      ptr       <= 2'd3;
      cnt       <= '0;
      gnt       <= 4'b0000;
      s1        <= 1'b0;
      s0        <= 1'b0;
      out       <= '0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= |gnt;
      if (|gnt) out <= sel_data;

      if (take) begin
        state    <= GRANT;
        ptr      <= pick_idx;
        cnt      <= '0;
        gnt      <= idx_onehot(pick_idx);
        {s1, s0} <= pick_idx;
      end else begin
        case (state)
          IDLE: ;
          GRANT: begin
            if (!req[ptr]) begin
              state <= IDLE;
              gnt   <= 4'b0000;
              cnt   <= '0;
            end else if (cnt != CNT_LAST) begin
              cnt <= cnt + 1'b1;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_mux4_rr_arbiter.sv
// Self-checking bench for mux4_rr_arbiter: directed scenarios plus a
// randomized run against a behavioural round-robin model.
module tb_mux4_rr_arbiter;

  localparam int W        = 8;
  localparam int MAX_HOLD = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic [3:0]   req;
  logic [W-1:0] dat [4];
  logic [3:0]   gnt;
  logic         s1, s0;
  logic [W-1:0] out;
  logic         out_valid;

  int n_vec = 0;
  int n_err = 0;

  // behavioural model state
  int           m_holder = -1;
  int           m_last   = 3;
  int           m_run    = 0;
  int           m_sel    = 0;
  logic [3:0]   m_gnt    = 4'b0000;
  logic [W-1:0] m_out    = '0;
  logic         m_valid  = 1'b0;

  always #5 clk = ~clk;

  mux4_rr_arbiter #(.W(W), .MAX_HOLD(MAX_HOLD)) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .i0        (dat[0]),
    .i1        (dat[1]),
    .i2        (dat[2]),
    .i3        (dat[3]),
    .gnt       (gnt),
    .s1        (s1),
    .s0        (s0),
    .out       (out),
    .out_valid (out_valid)
  );

  function automatic int rr_from(input int last, input logic [3:0] mask);
    for (int k = 1; k <= 4; k++) begin
      if (mask[(last + k) % 4]) return (last + k) % 4;
    end
    return -1;
  endfunction

  // One clock edge of the model, from the inputs as seen at that edge.
  task automatic model_step();
    logic [3:0] others;
    int         n;
    if (rst) begin
      m_holder = -1; m_last = 3; m_run = 0; m_sel = 0;
      m_gnt = 4'b0000; m_out = '0; m_valid = 1'b0;
      return;
    end
    if (m_gnt != 4'b0000) m_out = dat[m_sel];
    m_valid = (m_gnt != 4'b0000);
    others = req;
    if (m_holder >= 0) others[m_holder] = 1'b0;
    n = -1;
    if (m_holder < 0) begin
      if (req != 4'b0000) n = rr_from(m_last, req);
    end else if (!req[m_holder]) begin
      if (others != 4'b0000) n = rr_from(m_last, others);
      else m_holder = -1;
    end else if (m_run >= MAX_HOLD && others != 4'b0000) begin
      n = rr_from(m_last, others);
    end else begin
      m_run++;
    end
    if (n >= 0) begin
      m_holder = n; m_last = n; m_run = 1; m_sel = n;
    end
    m_gnt = (m_holder < 0) ? 4'b0000 : (4'b0001 << m_holder);
  endtask

  // Inputs are stable across the edge; outputs are sampled on the falling edge.
  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1; req = 4'b0000;
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; req = 4'b1111;
    for (int k = 0; k < 4; k++) dat[k] = 8'hA5;
    tick();
    n_vec++; if (gnt !== 4'b0000) begin n_err++; $display("FAIL reset_gnt: got %b want 0000", gnt); end
    n_vec++; if ({s1, s0} !== 2'b00) begin n_err++; $display("FAIL reset_sel: got %b want 00", {s1, s0}); end
    n_vec++; if (out !== 8'h00) begin n_err++; $display("FAIL reset_out: got %h want 00", out); end
    n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid: got %b want 0", out_valid); end
    rst = 1'b0; req = 4'b0000;
  endtask

  task automatic test_first_grant();
    do_reset();
    for (int k = 0; k < 4; k++) dat[k] = 8'h00;
    dat[2] = 8'h01; req = 4'b0100;
    tick();
    n_vec++; if (gnt !== 4'b0100) begin n_err++; $display("FAIL first_gnt: got %b want 0100", gnt); end
    n_vec++; if ({s1, s0} !== 2'b10) begin n_err++; $display("FAIL first_sel: got %b want 10", {s1, s0}); end
    n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL first_valid_early: got %b want 0", out_valid); end
    tick();
    n_vec++; if (out !== 8'h01) begin n_err++; $display("FAIL first_out: got %h want 01", out); end
    n_vec++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL first_valid: got %b want 1", out_valid); end
  endtask

  task automatic test_round_robin();
    logic [3:0] want;
    do_reset();
    req = 4'b1111;
    for (int j = 0; j < 20; j++) begin
      tick();
      want = 4'b0001 << ((j / MAX_HOLD) % 4);
      n_vec++;
      if (gnt !== want) begin
        n_err++; $display("FAIL rr_seq[%0d]: got %b want %b", j, gnt, want);
      end
    end
  endtask

  task automatic test_sole_saturate();
    do_reset();
    req = 4'b0010;
    for (int j = 0; j < 20; j++) begin
      tick();
      n_vec++;
      if (gnt !== 4'b0010) begin n_err++; $display("FAIL sole_hold[%0d]: got %b want 0010", j, gnt); end
    end
    req = 4'b0011;
    tick();
    n_vec++; if (gnt !== 4'b0001) begin n_err++; $display("FAIL sole_switch: got %b want 0001", gnt); end
  endtask

  task automatic test_release();
    do_reset();
    req = 4'b1010;
    tick();
    n_vec++; if (gnt !== 4'b0010) begin n_err++; $display("FAIL rel_first: got %b want 0010", gnt); end
    req = 4'b1000;
    tick();
    n_vec++; if (gnt !== 4'b1000) begin n_err++; $display("FAIL rel_handoff: got %b want 1000", gnt); end
    n_vec++; if ({s1, s0} !== 2'b11) begin n_err++; $display("FAIL rel_sel: got %b want 11", {s1, s0}); end
    req = 4'b0000;
    tick();
    n_vec++; if (gnt !== 4'b0000) begin n_err++; $display("FAIL rel_idle: got %b want 0000", gnt); end
    n_vec++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL rel_valid_tail: got %b want 1", out_valid); end
    n_vec++; if ({s1, s0} !== 2'b11) begin n_err++; $display("FAIL rel_sel_hold: got %b want 11", {s1, s0}); end
    tick();
    n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL rel_valid_drop: got %b want 0", out_valid); end
  endtask

  task automatic test_reset_mid();
    bit seen;
    do_reset();
    req = 4'b1111;
    seen = 1'b0;
    for (int j = 0; j < 16 && !seen; j++) begin
      tick();
      if (gnt === 4'b0100) seen = 1'b1;
    end
    n_vec++; if (!seen) begin n_err++; $display("FAIL midrst_reach: got %b want 0100 within 16 cycles", gnt); end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    n_vec++; if (gnt !== 4'b0000) begin n_err++; $display("FAIL midrst_gnt: got %b want 0000", gnt); end
    n_vec++; if ({s1, s0} !== 2'b00) begin n_err++; $display("FAIL midrst_sel: got %b want 00", {s1, s0}); end
    n_vec++; if (out !== 8'h00) begin n_err++; $display("FAIL midrst_out: got %h want 00", out); end
    n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL midrst_valid: got %b want 0", out_valid); end
    tick();
    n_vec++; if (gnt !== 4'b0001) begin n_err++; $display("FAIL midrst_next: got %b want 0001", gnt); end
  endtask

  task automatic test_random();
    int wait_cnt [4];
    do_reset();
    for (int k = 0; k < 4; k++) wait_cnt[k] = 0;
    req = 4'($urandom_range(0, 15));
    for (int j = 0; j < 600; j++) begin
      for (int k = 0; k < 4; k++) dat[k] = W'($urandom);
      tick();
      n_vec++;
      if (gnt !== m_gnt) begin n_err++; $display("FAIL rnd_gnt[%0d]: got %b want %b", j, gnt, m_gnt); end
      n_vec++;
      if ({s1, s0} !== 2'(m_sel)) begin n_err++; $display("FAIL rnd_sel[%0d]: got %b want %0d", j, {s1, s0}, m_sel); end
      n_vec++;
      if (out !== m_out) begin n_err++; $display("FAIL rnd_out[%0d]: got %h want %h", j, out, m_out); end
      n_vec++;
      if (out_valid !== m_valid) begin n_err++; $display("FAIL rnd_valid[%0d]: got %b want %b", j, out_valid, m_valid); end
      n_vec++;
      if ($countones(gnt) > 1) begin n_err++; $display("FAIL rnd_onehot[%0d]: got %b want at most one bit", j, gnt); end
      for (int k = 0; k < 4; k++) begin
        if (req[k] && !gnt[k]) wait_cnt[k]++;
        else wait_cnt[k] = 0;
        if (wait_cnt[k] > 3 * MAX_HOLD) begin
          n_vec++; n_err++;
          $display("FAIL rnd_starve[%0d] req %0d: waited %0d want <= %0d", j, k, wait_cnt[k], 3 * MAX_HOLD);
          wait_cnt[k] = 0;
        end
      end
      for (int k = 0; k < 4; k++) begin
        if ($urandom_range(0, 9) == 0) req[k] = ~req[k];
      end
      if ($urandom_range(0, 49) == 0) req = 4'b1111;
    end
  endtask

  initial begin
    rst = 1'b1; req = 4'b0000;
    for (int k = 0; k < 4; k++) dat[k] = '0;
    @(negedge clk);
    test_reset();
    test_first_grant();
    test_round_robin();
    test_sole_saturate();
    test_release();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
